funct_gen_ctrl: RTL and testbench

Controller that configures and sequences funct_generator on behalf of a host. It accepts a configuration transaction (amplitude, waveform select, burst length), replays it into the generator's config port, then enables generation and counts written samples. Generation pauses on FIFO full and stops on burst completion or host stop. Sits between the host/register interface and funct_generator; observes the generator's FIFO write strobe and the FIFO full flag.

---
 rtl/fifo_defines_pkg.sv | 20 ++
 rtl/funct_gen_ctrl_burst_counter.sv | 46 ++++
 rtl/funct_gen_ctrl.sv | 151 +++++++++++++++
 tb/tb_funct_gen_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_defines_pkg.sv
// Shared definitions for the function-generator datapath and its controller.
package fifo_defines_pkg;

  // Width of the signed amplitude word handed to funct_generator.
  localparam int INT_BITS = 12;

  // Controller defaults: burst/sample counter width and config strobe length.
  localparam int BURST_W_DEF     = 16;
  localparam int CONF_CYCLES_DEF = 2;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONFIG = 3'd1,
    RUN    = 3'd2,
    PAUSE  = 3'd3,
    DONE   = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/funct_gen_ctrl_burst_counter.sv
// Sample counter for one burst: clearable, saturating, with a length-hit flag
// that fires on the strobe that brings the count up to a non-zero length.
module burst_counter
  import fifo_defines_pkg::*;
#(
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               inc_i,
  input  logic [BURST_W-1:0] len_i,
  output logic [BURST_W-1:0] count_o,
  output logic               hit_o
);

  logic [BURST_W-1:0] count_q;
  logic [BURST_W-1:0] count_d;
  logic [BURST_W:0]   count_plus1;

  // One extra bit so a saturated counter never aliases to a small length.
  assign count_plus1 = {1'b0, count_q} + {{BURST_W{1'b0}}, 1'b1};

  assign hit_o   = (len_i != '0) && inc_i && (count_plus1 == {1'b0, len_i});
  assign count_o = count_q;

  // Next count: clear wins, otherwise increment until all-ones and hold there.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_plus1[BURST_W-1:0];
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/funct_gen_ctrl.sv
// Host-side controller for funct_generator: loads a configuration into the
// generator, then runs, pauses on FIFO full and stops on burst end or abort.
module funct_gen_ctrl
  import fifo_defines_pkg::*;
#(
  parameter int BURST_W     = BURST_W_DEF,
  parameter int CONF_CYCLES = CONF_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic signed [INT_BITS-1:0] cfg_amp_i,
  input  logic [1:0]                 cfg_sel_i,
  input  logic [BURST_W-1:0]         cfg_len_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  output logic                       gen_en_low_o,
  output logic                       gen_enh_conf_o,
  output logic signed [INT_BITS-1:0] gen_amp_o,
  output logic [1:0]                 gen_sel_o,
  input  logic                       gen_wr_en_i,
  input  logic                       fifo_full_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [BURST_W-1:0]         sample_cnt_o
);

  localparam int CONF_W = (CONF_CYCLES > 1) ? $clog2(CONF_CYCLES) : 1;
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONF_CYCLES - 1);

  ctrl_state_t state_q;
  ctrl_state_t state_d;

  logic [CONF_W-1:0]          conf_cnt_q;
  logic                       cfg_loaded_q;
  logic signed [INT_BITS-1:0] amp_q;
  logic [1:0]                 sel_q;
  logic [BURST_W-1:0]         len_q;

  logic ready_q;
  logic en_low_q;
  logic enh_conf_q;
  logic busy_q;
  logic done_q;

  logic cfg_accept;
  logic run_start;
  logic conf_last;
  logic cnt_inc;
  logic len_hit;

  // A config takes precedence over start in IDLE; start needs a loaded config.
  assign cfg_accept = (state_q == IDLE) && cfg_valid_i;
  assign run_start  = (state_q == IDLE) && !cfg_valid_i && start_i && cfg_loaded_q;
  assign conf_last  = (state_q == CONFIG) && (conf_cnt_q == CONF_LAST);
  // Writes already in flight when we pause still land in the FIFO, so count them.
  assign cnt_inc    = gen_wr_en_i && ((state_q == RUN) || (state_q == PAUSE));

  burst_counter #(
    .BURST_W (BURST_W)
  ) u_burst_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (run_start),
    .inc_i   (cnt_inc),
    .len_i   (len_q),
    .count_o (sample_cnt_o),
    .hit_o   (len_hit)
  );

  // Next-state selection; in RUN an abort beats burst end, which beats backpressure.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i)    state_d = CONFIG;
        else if (run_start) state_d = RUN;
      end
      CONFIG: begin
        if (conf_last) state_d = IDLE;
      end
      RUN: begin
        if (stop_i)           state_d = DONE;
        else if (len_hit)     state_d = DONE;
        else if (fifo_full_i) state_d = PAUSE;
      end
      PAUSE: begin
        if (stop_i)            state_d = DONE;
        else if (!fifo_full_i) state_d = RUN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with outputs registered from the next state, so each output is a clean Moore decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      en_low_q   <= 1'b1;
      enh_conf_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= (state_d == IDLE);
      en_low_q   <= (state_d != RUN);
      enh_conf_q <= (state_d == CONFIG);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  // Configuration shadows, config-strobe counter and the loaded flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      amp_q        <= '0;
      sel_q        <= '0;
      len_q        <= '0;
      conf_cnt_q   <= '0;
      cfg_loaded_q <= 1'b0;
    end else begin
      if (cfg_accept) begin
        amp_q      <= cfg_amp_i;
        sel_q      <= cfg_sel_i;
        len_q      <= cfg_len_i;
        conf_cnt_q <= '0;
      end else if (state_q == CONFIG) begin
        conf_cnt_q <= conf_cnt_q + 1'b1;
      end
      if (conf_last) begin
        cfg_loaded_q <= 1'b1;
      end
    end
  end

  assign cfg_ready_o    = ready_q;
  assign gen_en_low_o   = en_low_q;
  assign gen_enh_conf_o = enh_conf_q;
  assign gen_amp_o      = amp_q;
  assign gen_sel_o      = sel_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_funct_gen_ctrl.sv
// Directed self-checking bench for funct_gen_ctrl.
module tb_funct_gen_ctrl;
  import fifo_defines_pkg::*;

  localparam int BW = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfgValid = 1'b0;
  logic                cfgReady;
  logic [INT_BITS-1:0] cfgAmp = '0;
  logic [1:0]          cfgSel = '0;
  logic [BW-1:0]       cfgLen = '0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                genEnLow;
  logic                genEnhConf;
  logic [INT_BITS-1:0] genAmp;
  logic [1:0]          genSel;
  logic                genWrEn = 1'b0;
  logic                fifoFull = 1'b0;
  logic                busy;
  logic                done;
  logic [BW-1:0]       sampleCnt;

  int testsRun = 0;
  int testsFailed = 0;

  logic [INT_BITS-1:0] negAmp;

  funct_gen_ctrl #(
    .BURST_W     (BW),
    .CONF_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid_i    (cfgValid),
    .cfg_ready_o    (cfgReady),
    .cfg_amp_i      (cfgAmp),
    .cfg_sel_i      (cfgSel),
    .cfg_len_i      (cfgLen),
    .start_i        (start),
    .stop_i         (stop),
    .gen_en_low_o   (genEnLow),
    .gen_enh_conf_o (genEnhConf),
    .gen_amp_o      (genAmp),
    .gen_sel_o      (genSel),
    .gen_wr_en_i    (genWrEn),
    .fifo_full_i    (fifoFull),
    .busy_o         (busy),
    .done_o         (done),
    .sample_cnt_o   (sampleCnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic applyStimulus(input logic cv, input logic [INT_BITS-1:0] amp, input logic [1:0] sel,
                               input logic [BW-1:0] len, input logic st, input logic sp,
                               input logic wr, input logic full);
    cfgValid = cv;
    cfgAmp   = amp;
    cfgSel   = sel;
    cfgLen   = len;
    start    = st;
    stop     = sp;
    genWrEn  = wr;
    fifoFull = full;
    @(posedge clk);
    #1;
  endtask

  // All outputs must sit at their reset values.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, " ready"},    {31'd0, cfgReady},   32'd1);
    checkOutput({tag, " en_low"},   {31'd0, genEnLow},   32'd1);
    checkOutput({tag, " enh_conf"}, {31'd0, genEnhConf}, 32'd0);
    checkOutput({tag, " amp"},      {20'd0, genAmp},     32'd0);
    checkOutput({tag, " sel"},      {30'd0, genSel},     32'd0);
    checkOutput({tag, " busy"},     {31'd0, busy},       32'd0);
    checkOutput({tag, " done"},     {31'd0, done},       32'd0);
    checkOutput({tag, " count"},    {16'd0, sampleCnt},  32'd0);
  endtask

  // Safety net in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    negAmp = INT_BITS'(-3);

    // Power-on reset.
    #2 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Start with no configuration loaded is ignored.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("nocfg busy", {31'd0, busy}, 32'd0);
    checkOutput("nocfg en_low", {31'd0, genEnLow}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("nocfg still idle", {31'd0, cfgReady}, 32'd1);

    // Configuration handshake: amp=5, sel=2, len=4.
    applyStimulus(1, 5, 2, 4, 0, 0, 0, 0);
    checkOutput("cfg1 ready", {31'd0, cfgReady}, 32'd0);
    checkOutput("cfg1 enh", {31'd0, genEnhConf}, 32'd1);
    checkOutput("cfg1 amp", {20'd0, genAmp}, 32'd5);
    checkOutput("cfg1 sel", {30'd0, genSel}, 32'd2);
    checkOutput("cfg1 busy", {31'd0, busy}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cfg2 enh", {31'd0, genEnhConf}, 32'd1);
    checkOutput("cfg2 ready", {31'd0, cfgReady}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cfg3 enh", {31'd0, genEnhConf}, 32'd0);
    checkOutput("cfg3 ready", {31'd0, cfgReady}, 32'd1);
    checkOutput("cfg3 amp hold", {20'd0, genAmp}, 32'd5);
    checkOutput("cfg3 busy", {31'd0, busy}, 32'd0);

    // Burst of 4 with a strobe every cycle.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("b4 run en_low", {31'd0, genEnLow}, 32'd0);
    checkOutput("b4 run count", {16'd0, sampleCnt}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("b4 count", {16'd0, sampleCnt}, 32'(i));
      checkOutput("b4 no done", {31'd0, done}, 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("b4 done", {31'd0, done}, 32'd1);
    checkOutput("b4 final count", {16'd0, sampleCnt}, 32'd4);
    checkOutput("b4 done en_low", {31'd0, genEnLow}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("b4 done pulse", {31'd0, done}, 32'd0);
    checkOutput("b4 count hold", {16'd0, sampleCnt}, 32'd4);
    checkOutput("b4 idle", {31'd0, cfgReady}, 32'd1);

    // Reconfigure: amp=-3, sel=1, len=8.
    applyStimulus(1, negAmp, 1, 8, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cfg8 amp", {20'd0, genAmp}, 32'h00000FFD);
    checkOutput("cfg8 sel", {30'd0, genSel}, 32'd1);

    // Backpressure: 3 cycles of full mid-burst, one in-flight write in PAUSE.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("bp pre count", {16'd0, sampleCnt}, 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("bp pause1 en_low", {31'd0, genEnLow}, 32'd1);
    checkOutput("bp pause1 count", {16'd0, sampleCnt}, 32'd4);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("bp pause2 en_low", {31'd0, genEnLow}, 32'd1);
    checkOutput("bp inflight count", {16'd0, sampleCnt}, 32'd5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("bp pause3 en_low", {31'd0, genEnLow}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("bp resume en_low", {31'd0, genEnLow}, 32'd0);
    checkOutput("bp resume count", {16'd0, sampleCnt}, 32'd5);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("bp no early done", {31'd0, done}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("bp done", {31'd0, done}, 32'd1);
    checkOutput("bp final count", {16'd0, sampleCnt}, 32'd8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Priority: stop, full and length hit together go straight to DONE.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("prio cleared count", {16'd0, sampleCnt}, 32'd0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
    checkOutput("prio done", {31'd0, done}, 32'd1);
    checkOutput("prio count", {16'd0, sampleCnt}, 32'd8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("prio idle ready", {31'd0, cfgReady}, 32'd1);
    checkOutput("prio idle busy", {31'd0, busy}, 32'd0);

    // Config and start together: config wins, start dropped (len=0 loaded).
    applyStimulus(1, 7, 3, 0, 1, 0, 0, 0);
    checkOutput("cfgstart enh", {31'd0, genEnhConf}, 32'd1);
    checkOutput("cfgstart en_low", {31'd0, genEnLow}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cfgstart idle busy", {31'd0, busy}, 32'd0);
    checkOutput("cfgstart count kept", {16'd0, sampleCnt}, 32'd8);

    // Continuous mode: 20 strobes, then stop.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("cont no done", {31'd0, done}, 32'd0);
    end
    checkOutput("cont running", {31'd0, genEnLow}, 32'd0);
    checkOutput("cont count", {16'd0, sampleCnt}, 32'd20);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("cont stop done", {31'd0, done}, 32'd1);
    checkOutput("cont stop count", {16'd0, sampleCnt}, 32'd20);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a run at count 3.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("midrst pre count", {16'd0, sampleCnt}, 32'd3);
    #2 rst = 1'b0;
    #1;
    checkResetValues("midrst");
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("postrst start busy", {31'd0, busy}, 32'd0);
    checkOutput("postrst start en_low", {31'd0, genEnLow}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("postrst idle ready", {31'd0, cfgReady}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
